// File: rtl/tug_match_ctrl.sv
// Match sequencer for tug-of-war: gates keys into the playfield, turns a round end
// into one score pulse, freezes the field between rounds and latches the match winner.
module tug_match_ctrl #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       key_l_i,
  input  logic       key_r_i,
  input  logic       field_win_l_i,
  input  logic       field_win_r_i,
  input  logic       over_l_i,
  input  logic       over_r_i,
  output logic       play_key_l_o,
  output logic       play_key_r_o,
  output logic       win_l_o,
  output logic       win_r_o,
  output logic       field_clr_o,
  output logic       score_clr_o,
  output logic       match_over_o,
  output logic [1:0] winner_o,
  output logic [3:0] rounds_o
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  // The counter runs HOLD_LOAD..0, giving exactly HOLD_CYCLES cycles in HOLD.
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    PLAY  = 3'd2,
    SCORE = 3'd3,
    WAIT  = 3'd4,
    OVER  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          side_q, side_d;      // 0 = left scored, 1 = right scored
  logic [3:0]    rounds_q, rounds_d;
  logic [1:0]    winner_q, winner_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      side_q   <= 1'b0;
      rounds_q <= 4'd0;
      winner_q <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      side_q   <= side_d;
      rounds_q <= rounds_d;
      winner_q <= winner_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    side_d   = side_q;
    rounds_d = rounds_q;
    winner_d = winner_q;
    case (state_q)
      IDLE: begin
        rounds_d = 4'd0;
        winner_d = 2'b00;
        if (start_i) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (cnt_q == '0) state_d = PLAY;
        else             cnt_d   = cnt_q - CW'(1);
      end
      PLAY: begin
        // A simultaneous arrival at both ends is a tie: replay without scoring.
        if (field_win_l_i && field_win_r_i) begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else if (field_win_l_i) begin
          state_d = SCORE;
          side_d  = 1'b0;
        end else if (field_win_r_i) begin
          state_d = SCORE;
          side_d  = 1'b1;
        end
      end
      SCORE: begin
        if (rounds_q != 4'hF) rounds_d = rounds_q + 4'd1;
        state_d = WAIT;
      end
      WAIT: begin
        if (over_l_i) begin
          state_d  = OVER;
          winner_d = 2'b01;
        end else if (over_r_i) begin
          state_d  = OVER;
          winner_d = 2'b10;
        end else begin
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end
      OVER: begin
        if (start_i) begin
          state_d  = IDLE;
          rounds_d = 4'd0;
          winner_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign play_key_l_o = key_l_i && (state_q == PLAY);
  assign play_key_r_o = key_r_i && (state_q == PLAY);
  assign win_l_o      = (state_q == SCORE) && !side_q;
  assign win_r_o      = (state_q == SCORE) &&  side_q;
  assign field_clr_o  = (state_q != PLAY);
  assign score_clr_o  = (state_q == IDLE);
  assign match_over_o = (state_q == OVER);
  assign winner_o     = winner_q;
  assign rounds_o     = rounds_q;

endmodule
